// File: rtl/goertzel_bin_detector_pkg.sv
// Shared DSP constants for the Goertzel bin detector: run/bin index widths,
// frame-tracking state encoding and a small saturating-counter helper.
package goertzel_bin_detector_pkg;

  localparam int BIN_W = 5;  // bin index width
  localparam int RUN_W = 5;  // run-count width shared with the upstream manager
  localparam int CNT_W = 4;  // debounce counter width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EVAL  = 2'd2
  } gbd_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/goertzel_bin_detector_debounce.sv
// Hit/miss debouncer: a tone is declared after DEBOUNCE consecutive hit frames
// on the same bin and released after DEBOUNCE consecutive miss frames.
module bin_debounce
  import goertzel_bin_detector_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             i_eval,
  input  logic             i_hit,
  input  logic [BIN_W-1:0] i_bin,
  output logic             o_detect,
  output logic [BIN_W-1:0] o_detect_bin
);

  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;
  logic [BIN_W-1:0] r_last_bin;
  logic             r_detect;
  logic [BIN_W-1:0] r_detect_bin;
  logic [CNT_W-1:0] w_hit_next;
  logic [CNT_W-1:0] w_miss_next;

  // A hit on a new bin restarts the run at one rather than zero.
  always_comb begin
    w_hit_next  = (i_bin == r_last_bin) ? sat_inc(r_hit_cnt) : CNT_W'(1);
    w_miss_next = sat_inc(r_miss_cnt);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_last_bin   <= '0;
      r_detect     <= 1'b0;
      r_detect_bin <= '0;
    end else if (i_eval) begin
      if (i_hit) begin
        r_hit_cnt  <= w_hit_next;
        r_miss_cnt <= '0;
        r_last_bin <= i_bin;
        if (!r_detect && (w_hit_next >= CNT_W'(DEBOUNCE))) begin
          r_detect     <= 1'b1;
          r_detect_bin <= i_bin;
        end
      end else begin
        r_hit_cnt  <= '0;
        r_miss_cnt <= w_miss_next;
        if (w_miss_next >= CNT_W'(DEBOUNCE)) r_detect <= 1'b0;
      end
    end
  end

  assign o_detect     = r_detect;
  assign o_detect_bin = r_detect_bin;

endmodule

// File: rtl/goertzel_bin_detector.sv
// Tracks the peak Goertzel magnitude across the bins of a frame, reports it
// once per frame and feeds the per-frame hit/miss result to the debouncer.
module goertzel_bin_detector
  import goertzel_bin_detector_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int M_W      = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [M_W-1:0]   mag_in,
  input  logic             mag_rdy,
  input  logic [RUN_W-1:0] num_runs,
  input  logic [M_W-1:0]   threshold,
  output logic [M_W-1:0]   peak_mag,
  output logic [BIN_W-1:0] peak_bin,
  output logic             frame_valid,
  output logic             detect,
  output logic [BIN_W-1:0] detect_bin
);

  gbd_state_e       r_state;
  logic [RUN_W-1:0] r_frame_len;
  logic [BIN_W-1:0] r_bin_idx;
  logic [M_W-1:0]   r_run_max;
  logic [BIN_W-1:0] r_run_arg;
  logic [M_W-1:0]   r_peak_mag;
  logic [BIN_W-1:0] r_peak_bin;
  logic             r_frame_valid;

  logic w_accept;
  logic w_eval;
  logic w_hit;
  logic w_last;

  assign w_accept = mag_rdy && (num_runs != '0);
  assign w_eval   = (r_state == ST_EVAL);
  assign w_hit    = (r_run_max >= threshold);
  assign w_last   = (r_bin_idx == BIN_W'(r_frame_len - RUN_W'(1)));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state       <= ST_IDLE;
      r_frame_len   <= '0;
      r_bin_idx     <= '0;
      r_run_max     <= '0;
      r_run_arg     <= '0;
      r_peak_mag    <= '0;
      r_peak_bin    <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_EVAL: begin
          if (r_state == ST_EVAL) begin
            r_peak_mag    <= r_run_max;
            r_peak_bin    <= r_run_arg;
            r_frame_valid <= 1'b1;
            r_state       <= ST_IDLE;
          end
          // A strobe in the EVAL cycle opens the next frame without a gap.
          if (w_accept) begin
            r_frame_len <= num_runs;
            r_bin_idx   <= BIN_W'(1);
            r_run_max   <= mag_in;
            r_run_arg   <= '0;
            r_state     <= (num_runs == RUN_W'(1)) ? ST_EVAL : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            if (mag_in > r_run_max) begin
              r_run_max <= mag_in;
              r_run_arg <= r_bin_idx;
            end
            r_bin_idx <= r_bin_idx + BIN_W'(1);
            if (w_last) r_state <= ST_EVAL;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  bin_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .i_eval       (w_eval),
    .i_hit        (w_hit),
    .i_bin        (r_run_arg),
    .o_detect     (detect),
    .o_detect_bin (detect_bin)
  );

  assign peak_mag    = r_peak_mag;
  assign peak_bin    = r_peak_bin;
  assign frame_valid = r_frame_valid;

endmodule

// File: tb/tb_goertzel_bin_detector.sv
// Directed table-driven bench for goertzel_bin_detector (DEBOUNCE=3, M_W=16),
// plus hand sequences for run-count changes, num_runs=0 and mid-frame reset.
module tb_goertzel_bin_detector;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [15:0] mag_in;
  logic        mag_rdy;
  logic [4:0]  num_runs;
  logic [15:0] threshold;
  logic [15:0] peak_mag;
  logic [4:0]  peak_bin;
  logic        frame_valid;
  logic        detect;
  logic [4:0]  detect_bin;

  int n_checks = 0;
  int n_errors = 0;
  int fv_count = 0;

  always #5 sys_clk = ~sys_clk;

  goertzel_bin_detector #(.DEBOUNCE(3), .M_W(16)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .mag_in      (mag_in),
    .mag_rdy     (mag_rdy),
    .num_runs    (num_runs),
    .threshold   (threshold),
    .peak_mag    (peak_mag),
    .peak_bin    (peak_bin),
    .frame_valid (frame_valid),
    .detect      (detect),
    .detect_bin  (detect_bin)
  );

  always @(negedge sys_clk) if (frame_valid) fv_count <= fv_count + 1;

  typedef struct {
    logic [4:0]       nr;
    logic [15:0]      thr;
    logic [3:0][15:0] m;
    logic [15:0]      pk;
    logic [4:0]       pb;
    logic             det;
    logic [4:0]       db;
    logic             chk_db;
  } frame_vec_t;

  function automatic frame_vec_t mk(input int nr, input int thr, input int m0, input int m1,
                                    input int m2, input int m3, input int pk, input int pb,
                                    input int det, input int db, input int chk_db);
    frame_vec_t v;
    v.nr = 5'(nr); v.thr = 16'(thr);
    v.m[0] = 16'(m0); v.m[1] = 16'(m1); v.m[2] = 16'(m2); v.m[3] = 16'(m3);
    v.pk = 16'(pk); v.pb = 5'(pb); v.det = 1'(det); v.db = 5'(db); v.chk_db = 1'(chk_db);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One strobe, then two idle cycles; frame_valid must appear exactly two
  // cycles after the strobe cycle when this is the frame's last bin.
  task automatic send_bin(input logic [15:0] m, input bit last);
    @(negedge sys_clk);
    mag_in  = m;
    mag_rdy = 1'b1;
    @(negedge sys_clk);
    mag_rdy = 1'b0;
    chk("fv_early", frame_valid, 0);
    @(negedge sys_clk);
    chk(last ? "fv_on_time" : "fv_idle", frame_valid, last);
  endtask

  frame_vec_t vec [18];
  int saved;

  initial begin
    vec[0]  = mk(4, 40, 10, 50, 50, 20,    50, 1, 0, 0, 1);   // tie keeps lower bin
    vec[1]  = mk(4, 40,  0,  0, 45,  0,    45, 2, 0, 0, 1);
    vec[2]  = mk(4, 40,  0,  0,  0, 41,    41, 3, 0, 0, 1);
    vec[3]  = mk(4, 40,  1,  1, 99,  1,    99, 2, 0, 0, 1);   // bins 2,3,2: no detect
    vec[4]  = mk(4, 40, 40, 40, 40, 40,    40, 0, 0, 0, 1);   // equal to threshold is a hit
    vec[5]  = mk(4, 40,  3,  7, 40, 39,    40, 2, 0, 0, 1);
    vec[6]  = mk(4, 40,  0,  0, 65535, 0, 65535, 2, 0, 0, 1);
    vec[7]  = mk(4, 40,  5,  6, 200, 7,   200, 2, 1, 2, 1);   // third bin-2 hit: rise
    vec[8]  = mk(4, 40,  0,  0,  0, 300,  300, 3, 1, 2, 1);   // other bin: detect_bin holds
    vec[9]  = mk(4, 40, 10, 20, 39,  5,    39, 2, 1, 2, 1);   // miss 1
    vec[10] = mk(4, 40,  0,  0,  0,  0,     0, 0, 1, 2, 1);   // miss 2
    vec[11] = mk(4, 40,  0, 100, 0,  0,   100, 1, 1, 2, 1);   // hit clears misses
    vec[12] = mk(4, 40,  1,  2,  3,  4,     4, 3, 1, 2, 1);
    vec[13] = mk(4, 40, 39, 38,  0,  0,    39, 0, 1, 2, 1);
    vec[14] = mk(4, 40,  9,  8,  7,  6,     9, 0, 0, 0, 0);   // third miss: fall
    vec[15] = mk(2,  5,  5,  9,  0,  0,     9, 1, 0, 0, 0);
    vec[16] = mk(1, 40, 41,  0,  0,  0,    41, 0, 0, 0, 0);
    vec[17] = mk(3, 40, 50, 60, 70,  0,    70, 2, 0, 0, 0);

    sys_rst = 1'b1; mag_in = '0; mag_rdy = 1'b0; num_runs = 5'd4; threshold = 16'd40;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("rst_peak_mag", peak_mag, 0);
    chk("rst_peak_bin", peak_bin, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_detect", detect, 0);
    chk("rst_detect_bin", detect_bin, 0);

    for (int i = 0; i < 18; i++) begin
      num_runs  = vec[i].nr;
      threshold = vec[i].thr;
      for (int j = 0; j < int'(vec[i].nr); j++)
        send_bin(vec[i].m[j], j == int'(vec[i].nr) - 1);
      chk("peak_mag", peak_mag, vec[i].pk);
      chk("peak_bin", peak_bin, vec[i].pb);
      chk("detect", detect, vec[i].det);
      if (vec[i].chk_db) chk("detect_bin", detect_bin, vec[i].db);
      $display("frame %0d: nr=%0d peak=%0d bin=%0d detect=%0d detect_bin=%0d",
               i, vec[i].nr, peak_mag, peak_bin, detect, detect_bin);
    end

    // num_runs=0: strobes are ignored, no frame ever completes
    num_runs = 5'd0;
    @(negedge sys_clk);
    saved = fv_count;
    for (int j = 0; j < 5; j++) send_bin(16'd500, 1'b0);
    @(negedge sys_clk);
    chk("nr0_no_frames", fv_count - saved, 0);
    $display("num_runs=0: frames=%0d", fv_count - saved);

    // run count changed mid-frame: frame length is frozen until the next frame
    num_runs = 5'd4;
    send_bin(16'd1, 1'b0);
    send_bin(16'd2, 1'b0);
    num_runs = 5'd2;
    send_bin(16'd3, 1'b0);
    send_bin(16'd4, 1'b1);
    chk("switch_peak_mag", peak_mag, 4);
    chk("switch_peak_bin", peak_bin, 3);
    send_bin(16'd7, 1'b0);
    send_bin(16'd6, 1'b1);
    chk("switch2_peak_mag", peak_mag, 7);
    chk("switch2_peak_bin", peak_bin, 0);
    $display("run-count switch: peak=%0d bin=%0d", peak_mag, peak_bin);

    // reset after bin 2 of 4, with a strobe coincident with reset
    num_runs = 5'd4;
    send_bin(16'd900, 1'b0);
    send_bin(16'd901, 1'b0);
    send_bin(16'd902, 1'b0);
    @(negedge sys_clk);
    saved   = fv_count;
    sys_rst = 1'b1;
    mag_rdy = 1'b1;
    mag_in  = 16'd999;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    mag_rdy = 1'b0;
    chk("mrst_peak_mag", peak_mag, 0);
    chk("mrst_peak_bin", peak_bin, 0);
    chk("mrst_frame_valid", frame_valid, 0);
    chk("mrst_detect", detect, 0);
    chk("mrst_detect_bin", detect_bin, 0);
    send_bin(16'd5, 1'b0);
    send_bin(16'd1, 1'b0);
    send_bin(16'd2, 1'b0);
    send_bin(16'd3, 1'b1);
    chk("post_rst_peak_mag", peak_mag, 5);
    chk("post_rst_peak_bin", peak_bin, 0);
    @(negedge sys_clk);
    chk("post_rst_frames", fv_count - saved, 1);
    $display("mid-frame reset: peak=%0d bin=%0d frames=%0d", peak_mag, peak_bin, fv_count - saved);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/goertzel_bin_detector.md
GOERTZEL_BIN_DETECTOR -- requirements
Module: goertzel_bin_detector

Interface
REQ-001 Parameter DEBOUNCE, default 3: consecutive frames needed to assert or release detect, range 1..15.
REQ-002 Parameter M_W, default 16: magnitude width.
REQ-003 sys_clk  in  1  sole clock; all logic updates on its rising edge.
REQ-004 sys_rst  in  1  reset, synchronous and active-high.
REQ-005 mag_in  in  M_W  Goertzel magnitude from the upstream manager; valid only while mag_rdy=1.
REQ-006 mag_rdy  in  1  one-cycle strobe, one per bin run; strobes are at least 2 cycles apart.
REQ-007 num_runs  in  5  bins per frame, same value driven to the upstream manager; 0 disables the block.
REQ-008 threshold  in  M_W  unsigned detection threshold.
REQ-009 peak_mag  out  M_W  largest magnitude of the last completed frame.
REQ-010 peak_bin  out  5  run index (0-based) of peak_mag.
REQ-011 frame_valid  out  1  one-cycle strobe when peak_mag and peak_bin update.
REQ-012 detect  out  1  debounced tone-present flag.
REQ-013 detect_bin  out  5  peak_bin captured when detect last rose; holds while detect=1.

Function
REQ-014 States: IDLE, ACCUM, EVAL; reset state is IDLE.
REQ-015 IDLE: on mag_rdy with num_runs!=0, latch num_runs into frame_len, set bin_idx=1, run_max=mag_in, run_arg=0; go to ACCUM, or straight to EVAL if frame_len=1.
REQ-016 mag_rdy with num_runs=0 is ignored in every state.
REQ-017 ACCUM: on mag_rdy, if mag_in > run_max (strict, unsigned) then run_max=mag_in and run_arg=bin_idx; bin_idx increments.
REQ-018 Ties keep the lower bin index.
REQ-019 ACCUM: when the strobe accepted is bin_idx = frame_len-1, go to EVAL on the next cycle.
REQ-020 frame_len is frozen for the whole frame; num_runs changes take effect at the next frame start.
REQ-021 EVAL lasts one cycle: peak_mag<=run_max, peak_bin<=run_arg, frame_valid=1; return to IDLE.
REQ-022 A mag_rdy arriving in the EVAL cycle is processed as bin 0 of a new frame, exactly as in IDLE; the state goes to ACCUM.
REQ-023 Latency: frame_valid asserts 2 cycles after the cycle in which the last bin's mag_rdy is high.
REQ-024 Hit frame: run_max >= threshold. Miss frame: otherwise. Classification is evaluated in EVAL.
REQ-025 hit_cnt and miss_cnt are 4-bit saturating counters.
REQ-026 A hit clears miss_cnt. A hit increments hit_cnt only if run_arg equals the previous hit frame's bin; otherwise hit_cnt=1.
REQ-027 A miss clears hit_cnt and increments miss_cnt.
REQ-028 detect rises in the EVAL cycle where the updated hit_cnt reaches DEBOUNCE; detect_bin<=run_arg at the same time.
REQ-029 detect falls in the EVAL cycle where the updated miss_cnt reaches DEBOUNCE.
REQ-030 While detect=1, hits on a different bin do not change detect_bin.
REQ-031 Registered outputs: detect, detect_bin, peak_mag and peak_bin update in the same cycle that frame_valid is high.

Reset
REQ-032 sys_rst=1 forces on the next edge: state=IDLE; peak_mag=0, peak_bin=0, frame_valid=0, detect=0, detect_bin=0; all counters, run_max, run_arg and frame_len = 0.
REQ-033 Reset mid-frame discards the partial frame; no frame_valid is produced for it.
REQ-034 mag_rdy in the same cycle as sys_rst=1 is ignored.

Structure
REQ-035 State encodings and the 5-bit bin-index width live in the shared DSP constants package, alongside the manager's run-count width.
REQ-036 The debounce hit/miss logic is one sub-module, bin_debounce: inputs evaluate strobe, hit, bin; outputs detect and detect_bin.
REQ-037 No multipliers or RAM are used; comparators and counters only.

Verification
REQ-038 num_runs=4, mags 10,50,50,20, threshold 40 -> frame_valid 2 cycles after bin 3; peak_mag=50, peak_bin=1 (tie keeps lower index).
REQ-039 DEBOUNCE=3, three frames peaking at bin 2 above threshold -> detect rises on frame 3, detect_bin=2; frames peaking at bins 2,3,2 -> detect stays 0.
REQ-040 detect=1, then three below-threshold frames -> detect falls on the third frame_valid; two misses followed by one hit -> detect stays 1.
REQ-041 num_runs=1 -> every mag_rdy yields frame_valid; num_runs=0 -> no frame_valid ever.
REQ-042 num_runs switched 4->2 after bin 1 -> current frame still completes after 4 bins; next frame completes after 2.
REQ-043 sys_rst asserted after bin 2 of 4 -> no frame_valid; all outputs 0; the next 4 strobes form a clean frame.
